ws2812_frame_master: RTL and testbench

- APB master sitting directly upstream of the WS2812 LED driver slave.
- Each frame, generates one colour per LED from a selectable effect (solid, chase, rainbow) and writes it to the driver's colour register at offset 0x08.
- After the writes, waits for the driver's end-of-frame interrupt, then a programmable gap, then starts the next frame.

---
 rtl/ws2812_frame_master.sv | 224 ++++++++++++++++++++++
 tb/tb_ws2812_frame_master.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_frame_master.sv
// WS2812 frame master: APB master that computes one colour per LED from a
// selectable effect (solid, chase, rainbow, off) and writes it to the LED
// driver's colour register, then waits for end-of-frame plus a gap.
// Optional build macro WS2812_BRIGHTNESS_EN adds brightness_i channel scaling.
module ws2812_frame_master #(
   parameter int unsigned LED_COUNT      = 3,
   parameter int unsigned HUE_STEP_LED   = 64,
   parameter int unsigned HUE_STEP_FRAME = 8,
   parameter int unsigned FRAME_GAP      = 1000,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk_i,
   input  logic        resetn_i,
   input  logic        enable_i,
   input  logic [1:0]  mode_i,
   input  logic [23:0] base_colour_i,
`ifdef WS2812_BRIGHTNESS_EN
   input  logic [7:0]  brightness_i,
`endif
   input  logic        frame_done_i,
   output logic        apb_psel_o,
   output logic        apb_penable_o,
   output logic        apb_pwrite_o,
   output logic [5:0]  apb_paddr_o,
   output logic [31:0] apb_pwdata_o,
   input  logic        apb_pready_i,
   input  logic        apb_pslverr_i,
   output logic        busy_o,
   output logic        err_o,
   output logic [15:0] frame_count_o
);

   localparam logic [7:0]  LastIdx  = 8'(LED_COUNT - 1);
   localparam logic [10:0] HueLed   = 11'(HUE_STEP_LED);
   localparam logic [10:0] HueFrame = 11'(HUE_STEP_FRAME);
   localparam logic [31:0] GapLast  = 32'((FRAME_GAP == 0) ? 0 : FRAME_GAP - 1);
   localparam logic [31:0] TmoLast  = 32'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StCalc, StSetup, StAccess, StWaitDone, StGap} state_e;

   state_e      state_q, state_d;
   logic [7:0]  led_idx_q, led_idx_d;
   logic [7:0]  chase_pos_q, chase_pos_d;
   logic [9:0]  frame_hue_q, frame_hue_d;
   logic [9:0]  hue_q, hue_d;
   logic [31:0] gap_cnt_q, gap_cnt_d;
   logic [31:0] tmo_cnt_q, tmo_cnt_d;
   logic        psel_q, psel_d;
   logic        penable_q, penable_d;
   logic [31:0] pwdata_q, pwdata_d;
   logic        busy_q, busy_d;
   logic        err_q, err_d;
   logic [15:0] frame_count_q, frame_count_d;
   logic [23:0] raw_colour, colour;

   // Hue addition modulo 768; both operands are below 768 so one subtract suffices.
   function automatic logic [9:0] hue_add(input logic [9:0] a, input logic [10:0] inc);
      logic [10:0] s;
      s = {1'b0, a} + inc;
      if (s >= 11'd768) s = s - 11'd768;
      return s[9:0];
   endfunction

`ifdef WS2812_BRIGHTNESS_EN
   function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
      logic [15:0] p;
      p = {8'h00, c} * ({8'h00, b} + 16'd1);
      return p[15:8];
   endfunction
`endif

   // Effect colour for the LED currently in CALC (GRB packing).
   always_comb begin
      logic [7:0] v, nv;
      logic [23:0] rainbow;
      v  = hue_q[7:0];
      nv = 8'hFF - v;
      unique case (hue_q[9:8])
         2'd0:    rainbow = {v, nv, 8'h00};
         2'd1:    rainbow = {nv, 8'h00, v};
         2'd2:    rainbow = {8'h00, v, nv};
         default: rainbow = 24'h0;
      endcase
      unique case (mode_i)
         2'd0:    raw_colour = base_colour_i;
         2'd1:    raw_colour = (led_idx_q == chase_pos_q) ? base_colour_i : 24'h0;
         2'd2:    raw_colour = rainbow;
         default: raw_colour = 24'h0;
      endcase
`ifdef WS2812_BRIGHTNESS_EN
      colour = {scale(raw_colour[23:16], brightness_i), scale(raw_colour[15:8], brightness_i),
                scale(raw_colour[7:0], brightness_i)};
`else
      colour = raw_colour;
`endif
   end

   // Frame sequencing and APB transfer next-state logic.
   always_comb begin
      state_d       = state_q;
      led_idx_d     = led_idx_q;
      chase_pos_d   = chase_pos_q;
      frame_hue_d   = frame_hue_q;
      hue_d         = hue_q;
      gap_cnt_d     = gap_cnt_q;
      tmo_cnt_d     = tmo_cnt_q;
      psel_d        = psel_q;
      penable_d     = penable_q;
      pwdata_d      = pwdata_q;
      err_d         = err_q;
      frame_count_d = frame_count_q;
      unique case (state_q)
         StIdle: begin
            if (enable_i) begin
               state_d   = StCalc;
               led_idx_d = 8'd0;
               hue_d     = frame_hue_q;
            end
         end
         StCalc: begin
            pwdata_d  = {led_idx_q, colour};
            psel_d    = 1'b1;
            penable_d = 1'b0;
            state_d   = StSetup;
         end
         StSetup: begin
            penable_d = 1'b1;
            tmo_cnt_d = 32'd0;
            state_d   = StAccess;
         end
         StAccess: begin
            // pready is checked first so it wins over a same-cycle timeout
            if (apb_pready_i) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               pwdata_d  = 32'h0;
               if (apb_pslverr_i) err_d = 1'b1;
               if (led_idx_q == LastIdx) begin
                  state_d = StWaitDone;
               end else begin
                  led_idx_d = led_idx_q + 8'd1;
                  hue_d     = hue_add(hue_q, HueLed);
                  state_d   = StCalc;
               end
            end else if (tmo_cnt_q == TmoLast) begin
               psel_d    = 1'b0;
               penable_d = 1'b0;
               pwdata_d  = 32'h0;
               err_d     = 1'b1;
               state_d   = StIdle;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 32'd1;
            end
         end
         StWaitDone: begin
            if (frame_done_i) begin
               frame_count_d = frame_count_q + 16'd1;
               chase_pos_d   = (chase_pos_q == LastIdx) ? 8'd0 : chase_pos_q + 8'd1;
               frame_hue_d   = hue_add(frame_hue_q, HueFrame);
               gap_cnt_d     = 32'd0;
               state_d       = StGap;
            end
         end
         StGap: begin
            if (gap_cnt_q == GapLast) begin
               if (enable_i) begin
                  state_d   = StCalc;
                  led_idx_d = 8'd0;
                  hue_d     = frame_hue_q;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + 32'd1;
            end
         end
         default: state_d = StIdle;
      endcase
      busy_d = (state_d != StIdle);
   end

   // State and registered outputs; reset drops the bus immediately.
   always_ff @(posedge clk_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q       <= StIdle;
         led_idx_q     <= 8'd0;
         chase_pos_q   <= 8'd0;
         frame_hue_q   <= 10'd0;
         hue_q         <= 10'd0;
         gap_cnt_q     <= 32'd0;
         tmo_cnt_q     <= 32'd0;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwdata_q      <= 32'h0;
         busy_q        <= 1'b0;
         err_q         <= 1'b0;
         frame_count_q <= 16'd0;
      end else begin
         state_q       <= state_d;
         led_idx_q     <= led_idx_d;
         chase_pos_q   <= chase_pos_d;
         frame_hue_q   <= frame_hue_d;
         hue_q         <= hue_d;
         gap_cnt_q     <= gap_cnt_d;
         tmo_cnt_q     <= tmo_cnt_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwdata_q      <= pwdata_d;
         busy_q        <= busy_d;
         err_q         <= err_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign apb_psel_o    = psel_q;
   assign apb_penable_o = penable_q;
   assign apb_pwrite_o  = psel_q;
   assign apb_paddr_o   = psel_q ? 6'h08 : 6'h00;
   assign apb_pwdata_o  = pwdata_q;
   assign busy_o        = busy_q;
   assign err_o         = err_q;
   assign frame_count_o = frame_count_q;

endmodule

// File: tb/tb_ws2812_frame_master.sv
// Scoreboard bench for ws2812_frame_master: expected APB writes are queued by
// the stimulus and popped by a monitor on each completed transfer.
module tb_ws2812_frame_master;

   localparam int unsigned Gap = 20;

   logic        clk, resetn, enable, frame_done;
   logic [1:0]  mode;
   logic [23:0] base;
`ifdef WS2812_BRIGHTNESS_EN
   logic [7:0]  brightness;
`endif
   logic        psel, penable, pwrite, pready, pslverr, busy, err;
   logic [5:0]  paddr;
   logic [31:0] pwdata;
   logic [15:0] frame_count;

   logic [31:0] exp_q[$];
   logic [31:0] exp_tab [0:3][0:2];
   int          n_checks = 0;
   int          n_pass = 0;
   int          wr_cnt = 0;
   bit          slave_stall = 0;
   bit          err_inject = 0;

   ws2812_frame_master #(
      .LED_COUNT(3), .HUE_STEP_LED(256), .HUE_STEP_FRAME(8),
      .FRAME_GAP(Gap), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk_i(clk), .resetn_i(resetn), .enable_i(enable), .mode_i(mode),
      .base_colour_i(base),
`ifdef WS2812_BRIGHTNESS_EN
      .brightness_i(brightness),
`endif
      .frame_done_i(frame_done), .apb_psel_o(psel), .apb_penable_o(penable),
      .apb_pwrite_o(pwrite), .apb_paddr_o(paddr), .apb_pwdata_o(pwdata),
      .apb_pready_i(pready), .apb_pslverr_i(pslverr), .busy_o(busy), .err_o(err),
      .frame_count_o(frame_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, want finish before time limit");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   // Slave: pready one cycle after penable, unless stalled.
   initial begin
      pready  = 1'b0;
      pslverr = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         pready  = !slave_stall && psel && penable && !pready;
         pslverr = pready && err_inject;
      end
   end

   // Monitor: every completed transfer is popped and compared.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (resetn && psel && penable && pready) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_write: got pwdata %h, want no transfer", pwdata);
            end else begin
               e = exp_q.pop_front();
               chk("apb_write", {25'b0, paddr, pwrite, pwdata}, {25'b0, 6'h08, 1'b1, e});
            end
         end
      end
   end

   task automatic wait_writes(input int target);
      int t = 0;
      while (wr_cnt < target && t < 2000) begin
         @(posedge clk);
         t++;
      end
      if (wr_cnt < target) chk("write_wait_expired", 64'(wr_cnt), 64'(target));
   endtask

   task automatic pulse_done(input int exp_cnt, input bit measure);
      int n = 0;
      @(negedge clk);
      frame_done = 1'b1;
      @(negedge clk);
      frame_done = 1'b0;
      chk("frame_count", 64'(frame_count), 64'(exp_cnt));
      if (measure) begin
         while (!psel && n < 500) begin
            @(posedge clk);
            #1;
            n++;
         end
         // Gap cycles plus the CALC cycle before SETUP raises psel.
         chk("gap_length", 64'(n), 64'(Gap + 1));
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      enable = 1'b0;
      repeat (2) @(negedge clk);
      resetn = 1'b1;
   endtask

   // Runs n frames from exp_tab, dropping enable during the last one.
   task automatic run_frames(input int n);
      int b = wr_cnt;
      for (int f = 0; f < n; f++) begin
         for (int l = 0; l < 3; l++) exp_q.push_back(exp_tab[f][l]);
         if (f == 0) begin
            @(negedge clk);
            enable = 1'b1;
         end else begin
            pulse_done(f, 1'b1);
         end
         if (f == n - 1) begin
            wait_writes(b + 3 * f + 1);
            @(negedge clk);
            enable = 1'b0;
         end
         wait_writes(b + 3 * f + 3);
         if (f == 0) begin
            repeat (4) @(negedge clk);
            chk("bus_idle_wait_done", {61'b0, psel, penable, busy}, 64'b001);
         end
      end
      pulse_done(n, 1'b0);
      repeat (Gap + 10) @(negedge clk);
      chk("idle_after_disable", 64'(busy), 64'd0);
      chk("write_total", 64'(wr_cnt), 64'(b + 3 * n));
      chk("frame_count_final", 64'(frame_count), 64'(n));
   endtask

   initial begin
      int t, cnt;
      resetn = 1'b0; enable = 1'b0; frame_done = 1'b0; mode = 2'd0; base = 24'h0;
`ifdef WS2812_BRIGHTNESS_EN
      brightness = 8'hFF;
`endif
      #1;
      chk("reset_bus", {25'b0, psel, penable, pwrite, paddr, pwdata}, 64'd0);
      chk("reset_status", {46'b0, busy, err, frame_count}, 64'd0);
      repeat (2) @(negedge clk);
      resetn = 1'b1;

      // Solid, two frames.
      mode = 2'd0; base = 24'h123456;
      for (int f = 0; f < 2; f++)
         for (int l = 0; l < 3; l++) exp_tab[f][l] = {8'(l), 24'h123456};
      run_frames(2);

      // Rainbow with HUE_STEP_LED=256, HUE_STEP_FRAME=8.
      do_reset();
      mode = 2'd2;
      exp_tab[0][0] = 32'h0000FF00; exp_tab[0][1] = 32'h01FF0000; exp_tab[0][2] = 32'h020000FF;
      exp_tab[1][0] = 32'h0008F700; exp_tab[1][1] = 32'h01F70008; exp_tab[1][2] = 32'h020008F7;
      run_frames(2);

      // Chase: lit LED follows the frame number.
      do_reset();
      mode = 2'd1; base = 24'hFFFFFF;
      for (int f = 0; f < 4; f++)
         for (int l = 0; l < 3; l++)
            exp_tab[f][l] = {8'(l), (l == f % 3) ? 24'hFFFFFF : 24'h000000};
      run_frames(4);

      // Timeout: slave never ready.
      do_reset();
      mode = 2'd0; base = 24'hABCDEF; slave_stall = 1'b1;
      @(negedge clk);
      enable = 1'b1;
      t = 0;
      while (!psel && t < 50) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("timeout_psel_rise", 64'(psel), 64'd1);
      enable = 1'b0;
      cnt = 0; t = 0;
      while (psel && t < 100) begin
         @(posedge clk);
         #1;
         t++;
         if (penable) cnt++;
      end
      chk("timeout_access_cycles", 64'(cnt), 64'd16);
      chk("timeout_err", 64'(err), 64'd1);
      chk("timeout_busy", 64'(busy), 64'd0);
      chk("timeout_frame_count", 64'(frame_count), 64'd0);
      slave_stall = 1'b0;

      // pslverr: error flagged, all writes still happen.
      do_reset();
      chk("err_cleared_by_reset", 64'(err), 64'd0);
      err_inject = 1'b1;
      for (int l = 0; l < 3; l++) exp_tab[0][l] = {8'(l), 24'h123456};
      base = 24'h123456;
      run_frames(1);
      chk("pslverr_err", 64'(err), 64'd1);
      err_inject = 1'b0;

      // Reset asserted during ACCESS.
      slave_stall = 1'b1; base = 24'h654321;
      @(negedge clk);
      enable = 1'b1;
      t = 0;
      while (!penable && t < 50) begin
         @(posedge clk);
         #1;
         t++;
      end
      chk("reach_access", 64'(penable), 64'd1);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("async_reset_bus", {62'b0, psel, penable}, 64'd0);
      chk("async_reset_status", {46'b0, busy, err, frame_count}, 64'd0);
      enable = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      slave_stall = 1'b0;
      for (int l = 0; l < 3; l++) exp_tab[0][l] = {8'(l), 24'h654321};
      run_frames(1);

`ifdef WS2812_BRIGHTNESS_EN
      do_reset();
      brightness = 8'h7F; base = 24'hFF8040;
      for (int l = 0; l < 3; l++) exp_tab[0][l] = {8'(l), 24'h7F4020};
      run_frames(1);
      brightness = 8'hFF;
`endif

      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
